// File: rtl/m_axi_lite_uart_ctrl.sv
// -----------------------------------------------------------------------------
// m_axi_lite_uart_ctrl
//
// AXI4-Lite master for the UART register-file slave (0x00 RX data, 0x04 TX data,
// 0x08 baud divisor, 0x0C frame config). A local controller issues one command
// at a time on the cmd port; the block performs a single-beat AXI-Lite write or
// read and returns the read data and response on the rsp port. A hung slave is
// detected by a timeout on the response phase (B or R channel).
//
// Ports
//   m_axi_aclk, m_axi_aresetn   clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready     command handshake; i_cmd_wr 1=write 0=read
//   i_cmd_addr, i_cmd_wdata     byte address and write data of the command
//   o_rsp_valid/i_rsp_ready     response handshake
//   o_rsp_rdata                 read data (0 for writes and timeouts)
//   o_rsp_resp                  BRESP/RRESP, 2'b10 on timeout
//   o_rsp_timeout               response phase timed out
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master channels (no PROT/STRB)
// -----------------------------------------------------------------------------
module m_axi_lite_uart_ctrl #(
    parameter int P_M_AXI_DATA_WIDTH = 32,
    parameter int P_M_AXI_ADDR_WIDTH = 16,
    parameter int P_TIMEOUT          = 1024
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_wr,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [P_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]                    o_rsp_resp,
    output logic                          o_rsp_timeout,
    output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);
    localparam int DW = P_M_AXI_DATA_WIDTH;
    localparam int AW = P_M_AXI_ADDR_WIDTH;
    localparam int CW = $clog2(P_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic            awvalid_reg, awvalid_next;
    logic            wvalid_reg, wvalid_next;
    logic            arvalid_reg, arvalid_next;
    logic            bready_reg, bready_next;
    logic            rready_reg, rready_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic            rsp_timeout_reg, rsp_timeout_next;
    logic [DW-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]      rsp_resp_reg, rsp_resp_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic aw_fire;
    logic w_fire;

    assign aw_fire = awvalid_reg & m_axi_awready;
    assign w_fire  = wvalid_reg & m_axi_wready;

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            bready_reg      <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b00;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            awvalid_reg     <= awvalid_next;
            wvalid_reg      <= wvalid_next;
            arvalid_reg     <= arvalid_next;
            bready_reg      <= bready_next;
            rready_reg      <= rready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_resp_reg    <= rsp_resp_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        awvalid_next     = awvalid_reg;
        wvalid_next      = wvalid_reg;
        arvalid_next     = arvalid_reg;
        bready_next      = bready_reg;
        rready_next      = rready_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_timeout_next = rsp_timeout_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_resp_next    = rsp_resp_reg;
        cnt_next         = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    addr_next  = i_cmd_addr;
                    wdata_next = i_cmd_wdata;
                    if (i_cmd_wr) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = ST_WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // A valid already low in this state means its handshake is done,
                // so AW and W complete independently without extra flags.
                if (aw_fire) awvalid_next = 1'b0;
                if (w_fire)  wvalid_next  = 1'b0;
                if ((!awvalid_reg || aw_fire) && (!wvalid_reg || w_fire)) begin
                    bready_next = 1'b1;
                    cnt_next    = '0;
                    state_next  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                // A handshake on the terminal-count cycle still wins over timeout.
                if (m_axi_bvalid && bready_reg) begin
                    bready_next      = 1'b0;
                    rsp_resp_next    = m_axi_bresp;
                    rsp_rdata_next   = '0;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RSP;
                end else if (cnt_reg == CNT_LAST) begin
                    bready_next      = 1'b0;
                    rsp_resp_next    = 2'b10;
                    rsp_rdata_next   = '0;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RSP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_RD_REQ: begin
                if (arvalid_reg && m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (m_axi_rvalid && rready_reg) begin
                    rready_next      = 1'b0;
                    rsp_resp_next    = m_axi_rresp;
                    rsp_rdata_next   = m_axi_rdata;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RSP;
                end else if (cnt_reg == CNT_LAST) begin
                    rready_next      = 1'b0;
                    rsp_resp_next    = 2'b10;
                    rsp_rdata_next   = '0;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RSP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_RSP: begin
                // Data/resp stay as last returned; only valid and the timeout flag clear.
                if (i_rsp_ready) begin
                    rsp_valid_next   = 1'b0;
                    rsp_timeout_next = 1'b0;
                    state_next       = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_cmd_ready   = (state_reg == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_reg;
    assign o_rsp_rdata   = rsp_rdata_reg;
    assign o_rsp_resp    = rsp_resp_reg;
    assign o_rsp_timeout = rsp_timeout_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_m_axi_lite_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_m_axi_lite_uart_ctrl
//
// Drives commands into m_axi_lite_uart_ctrl against a behavioural AXI-Lite slave
// whose ready/response delays and response codes are configurable per command.
// Expected response, latency and AXI beat counts are computed from the command
// and the slave configuration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_m_axi_lite_uart_ctrl;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TMO = 16;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_aresetn;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_wr;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rsp_valid, i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic [1:0]    o_rsp_resp;
    logic          o_rsp_timeout;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;

    // slave-side signals
    logic          awready_s, wready_s, arready_s, bvalid_s, rvalid_s;
    logic [1:0]    bresp_s, rresp_s;
    logic [DW-1:0] rdata_s;

    int checks = 0;
    int errors = 0;

    always #5 m_axi_aclk = ~m_axi_aclk;

    m_axi_lite_uart_ctrl #(
        .P_M_AXI_DATA_WIDTH(DW),
        .P_M_AXI_ADDR_WIDTH(AW),
        .P_TIMEOUT(TMO)
    ) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready_s),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready_s),
        .m_axi_bresp(bresp_s), .m_axi_bvalid(bvalid_s), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready_s),
        .m_axi_rdata(rdata_s), .m_axi_rresp(rresp_s), .m_axi_rvalid(rvalid_s),
        .m_axi_rready(m_axi_rready)
    );

    // ---------------- behavioural slave ----------------
    int          cfg_aw, cfg_w, cfg_ar, cfg_b, cfg_r;
    bit          cfg_b_never;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [DW-1:0] cfg_rdata;

    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int aw_beats, w_beats, ar_beats, b_beats, r_beats;
    logic aw_got, w_got, r_pend;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;

    wire aw_hs = m_axi_awvalid && awready_s;
    wire w_hs  = m_axi_wvalid && wready_s;
    wire ar_hs = m_axi_arvalid && arready_s;

    always @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            awready_s <= 1'b0; wready_s <= 1'b0; arready_s <= 1'b0;
            bvalid_s <= 1'b0; rvalid_s <= 1'b0;
            bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (aw_hs) begin
                awready_s <= 1'b0; aw_beats <= aw_beats + 1; last_awaddr <= m_axi_awaddr;
            end else if (m_axi_awvalid) begin
                if (aw_cnt >= cfg_aw) begin awready_s <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                wready_s <= 1'b0; w_beats <= w_beats + 1; last_wdata <= m_axi_wdata;
            end else if (m_axi_wvalid) begin
                if (w_cnt >= cfg_w) begin wready_s <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (ar_hs) begin
                arready_s <= 1'b0; ar_beats <= ar_beats + 1; last_araddr <= m_axi_araddr;
            end else if (m_axi_arvalid) begin
                if (ar_cnt >= cfg_ar) begin arready_s <= 1'b1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (bvalid_s && m_axi_bready) begin bvalid_s <= 1'b0; b_beats <= b_beats + 1; end
            if (!bvalid_s && !cfg_b_never && (aw_got || aw_hs) && (w_got || w_hs)) begin
                if (b_cnt >= cfg_b) begin
                    bvalid_s <= 1'b1; bresp_s <= cfg_bresp;
                    aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                end else begin
                    b_cnt <= b_cnt + 1; aw_got <= 1'b1; w_got <= 1'b1;
                end
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (rvalid_s && m_axi_rready) begin rvalid_s <= 1'b0; r_beats <= r_beats + 1; end
            if (!rvalid_s && (r_pend || ar_hs)) begin
                if (r_cnt >= cfg_r) begin
                    rvalid_s <= 1'b1; rdata_s <= cfg_rdata; rresp_s <= cfg_rresp;
                    r_pend <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1; r_pend <= 1'b1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                             input bit never, input logic [1:0] bresp, input logic [1:0] rresp,
                             input logic [DW-1:0] rdata);
        cfg_aw = aw; cfg_w = w; cfg_ar = ar; cfg_b = b; cfg_r = r;
        cfg_b_never = never; cfg_bresp = bresp; cfg_rresp = rresp; cfg_rdata = rdata;
    endtask

    // One complete command: issue, wait for the response, optionally stall
    // i_rsp_ready for 'hold' cycles, then consume the response.
    task automatic do_cmd(input string tag, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int hold, output int bready_cycles);
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
        logic          exp_to;
        int exp_lat, lat, guard, aw0, w0, ar0, slow;

        // reference model: outcome and latency follow from the slave configuration
        if (wr) begin
            slow = (cfg_aw > cfg_w) ? cfg_aw : cfg_w;
            exp_rdata = '0;
            if (cfg_b_never) begin
                exp_resp = 2'b10; exp_to = 1'b1; exp_lat = 3 + slow + TMO;
            end else begin
                exp_resp = cfg_bresp; exp_to = 1'b0; exp_lat = 4 + slow + cfg_b;
            end
        end else begin
            exp_rdata = cfg_rdata; exp_resp = cfg_rresp; exp_to = 1'b0;
            exp_lat = 4 + cfg_ar + cfg_r;
        end
        aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;

        i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wdata;
        guard = 0;
        while (!o_cmd_ready && guard < 50) begin tick(); guard++; end
        check({tag, "/cmd_ready"}, o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
        lat = 1; bready_cycles = 0;
        while (!o_rsp_valid && lat < 100) begin
            if (m_axi_bready) bready_cycles++;
            tick();
            lat++;
        end
        check({tag, "/rsp_valid"}, o_rsp_valid, 1);
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/rdata"}, o_rsp_rdata, exp_rdata);
        check({tag, "/resp"}, o_rsp_resp, exp_resp);
        check({tag, "/timeout"}, o_rsp_timeout, exp_to);
        check({tag, "/aw_beats"}, aw_beats - aw0, wr ? 1 : 0);
        check({tag, "/w_beats"}, w_beats - w0, wr ? 1 : 0);
        check({tag, "/ar_beats"}, ar_beats - ar0, wr ? 0 : 1);
        if (wr) begin
            check({tag, "/awaddr"}, last_awaddr, addr);
            check({tag, "/wdata"}, last_wdata, wdata);
        end else begin
            check({tag, "/araddr"}, last_araddr, addr);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "/hold_valid"}, o_rsp_valid, 1);
            check({tag, "/hold_rdata"}, o_rsp_rdata, exp_rdata);
            check({tag, "/hold_resp"}, o_rsp_resp, exp_resp);
            check({tag, "/hold_cmd_ready"}, o_cmd_ready, 0);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check({tag, "/rsp_done"}, o_rsp_valid, 0);
        check({tag, "/cmd_ready_after"}, o_cmd_ready, 1);
        $display("cmd %s wr=%0d addr=0x%04h rdata=0x%08h resp=%0d to=%0d lat=%0d",
                 tag, wr, addr, o_rsp_rdata, o_rsp_resp, o_rsp_timeout, lat);
    endtask

    task automatic bus_reset();
        m_axi_aresetn = 1'b0;
        tick(); tick();
        m_axi_aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, guard;
        m_axi_aresetn = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_rsp_ready = 1'b0;
        aw_beats = 0; w_beats = 0; ar_beats = 0; b_beats = 0; r_beats = 0;
        last_awaddr = '0; last_araddr = '0; last_wdata = '0;
        set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
        tick(); tick(); tick();

        // reset state
        check("rst/cmd_ready", o_cmd_ready, 1);
        check("rst/awvalid", m_axi_awvalid, 0);
        check("rst/wvalid", m_axi_wvalid, 0);
        check("rst/arvalid", m_axi_arvalid, 0);
        check("rst/bready", m_axi_bready, 0);
        check("rst/rready", m_axi_rready, 0);
        check("rst/rsp_valid", o_rsp_valid, 0);
        check("rst/timeout", o_rsp_timeout, 0);
        check("rst/awaddr", m_axi_awaddr, 0);
        check("rst/wdata", m_axi_wdata, 0);
        check("rst/rdata", o_rsp_rdata, 0);
        check("rst/resp", o_rsp_resp, 0);
        m_axi_aresetn = 1'b1;
        tick();

        // 1: write with delayed awready
        set_slave(3, 0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
        do_cmd("t1_wr_baud", 1'b1, 16'h0008, 32'h000001B2, 0, bc);

        // 2: read with late rvalid, then zero-wait read and write
        set_slave(0, 0, 0, 0, 2, 0, 2'b00, 2'b00, 32'h00000055);
        do_cmd("t2_rd_late", 1'b0, 16'h0000, '0, 0, bc);
        set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h000000A7);
        do_cmd("t2_rd_zw", 1'b0, 16'h0000, '0, 0, bc);
        do_cmd("t2_wr_zw", 1'b1, 16'h0004, 32'h00000041, 0, bc);

        // 3: B channel never answers
        set_slave(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, '0);
        do_cmd("t3_timeout", 1'b1, 16'h000C, 32'h00000003, 0, bc);
        check("t3/bready_cycles", bc, TMO);
        bus_reset();
        tick();

        // 4: slave error responses pass through
        set_slave(0, 0, 0, 0, 0, 0, 2'b10, 2'b11, 32'h12345678);
        do_cmd("t4_wr_slverr", 1'b1, 16'h0004, 32'h0000005A, 0, bc);
        do_cmd("t4_rd_decerr", 1'b0, 16'h0000, '0, 0, bc);

        // 5: stalled response, then back-to-back commands
        set_slave(1, 2, 1, 1, 1, 0, 2'b00, 2'b00, 32'hCAFE0001);
        do_cmd("t5_hold", 1'b0, 16'h0000, '0, 5, bc);
        set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h00000011);
        for (int k = 0; k < 4; k++) begin
            do_cmd("t5_b2b", k[0], 16'(4 * k), 32'hB000_0000 + 32'(k), 0, bc);
        end

        // 6: reset while waiting for R
        set_slave(0, 0, 0, 0, 8, 0, 2'b00, 2'b00, 32'h0000BEEF);
        i_cmd_valid = 1'b1; i_cmd_wr = 1'b0; i_cmd_addr = 16'h0000;
        tick();
        i_cmd_valid = 1'b0;
        guard = 0;
        while (!m_axi_rready && guard < 20) begin tick(); guard++; end
        check("t6/rready_before", m_axi_rready, 1);
        m_axi_aresetn = 1'b0;
        tick();
        check("t6/rready", m_axi_rready, 0);
        check("t6/rsp_valid", o_rsp_valid, 0);
        check("t6/cmd_ready", o_cmd_ready, 1);
        check("t6/arvalid", m_axi_arvalid, 0);
        m_axi_aresetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t6/no_rsp", o_rsp_valid, 0);
        end
        set_slave(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'h0000D00D);
        do_cmd("t6_recover", 1'b0, 16'h0008, '0, 0, bc);

        // randomized commands
        for (int n = 0; n < 20; n++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0,
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            do_cmd("rand", 1'($urandom_range(0, 1)), 16'(4 * $urandom_range(0, 3)),
                   $urandom, $urandom_range(0, 2), bc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
